// File: rtl/filter_ctrl_pkg.sv
// Shared mode codes, request-source encoding and mode helpers for the
// filter chain display-select controller.
package filter_ctrl_pkg;

    localparam logic [2:0] MODE_RGB    = 3'd0;
    localparam logic [2:0] MODE_GREY   = 3'd1;
    localparam logic [2:0] MODE_THR1   = 3'd2;
    localparam logic [2:0] MODE_BLUR   = 3'd3;
    localparam logic [2:0] MODE_THR2   = 3'd4;
    localparam logic [2:0] MODE_EDGE   = 3'd5;
    localparam logic [2:0] MODE_MIX    = 3'd6;

    localparam int NUM_MODES = 7;

    localparam logic SRC_CPU = 1'b0;
    localparam logic SRC_BTN = 1'b1;

    // single pending slot: mode waiting for a frame boundary and who asked
    typedef struct packed {
        logic [2:0] mode;
        logic       src;
    } pend_slot_t;

    function automatic logic [5:0] mode_to_onehot(input logic [2:0] mode);
        logic [5:0] oh;
        oh = 6'b000000;
        case (mode)
            MODE_GREY: oh = 6'b000001;
            MODE_THR1: oh = 6'b000010;
            MODE_BLUR: oh = 6'b000100;
            MODE_THR2: oh = 6'b001000;
            MODE_EDGE: oh = 6'b010000;
            MODE_MIX:  oh = 6'b100000;
            default:   oh = 6'b000000;
        endcase
        return oh;
    endfunction

    function automatic logic [2:0] next_mode(input logic [2:0] mode);
        return (mode >= MODE_MIX) ? MODE_RGB : mode + 3'd1;
    endfunction

endpackage

// File: rtl/frame_boundary_det.sv
// Derives a frame boundary from HSync/VDE: BLANK_LINES HSync rising edges
// with VDE low mark vertical blanking. Emits a combinational boundary strobe
// and a registered one-cycle frame_tick.
module frame_boundary_det #(
    parameter int BLANK_LINES = 2
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic HSync,
    input  logic VDE,
    output logic boundary,
    output logic frame_tick
);

    localparam int CW = 4;
    localparam logic [CW-1:0] CNT_MAX  = CW'(BLANK_LINES);
    localparam logic [CW-1:0] CNT_LAST = CW'(BLANK_LINES - 1);

    logic          hs_q;
    logic          hs_rise;
    logic [CW-1:0] blank_cnt;

    assign hs_rise  = HSync & ~hs_q;
    // fires only on the transition into the saturated count, so once per blanking
    assign boundary = hs_rise & ~VDE & (blank_cnt == CNT_LAST);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            hs_q       <= 1'b0;
            blank_cnt  <= '0;
            frame_tick <= 1'b0;
        end else begin
            hs_q       <= HSync;
            frame_tick <= boundary;
            if (VDE)
                blank_cnt <= '0;
            else if (hs_rise && blank_cnt != CNT_MAX)
                blank_cnt <= blank_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/filter_mode_ctrl.sv
// Display-select controller: arbitrates CPU and button mode requests into a
// single pending slot and applies it only at frame boundaries.
module filter_mode_ctrl
    import filter_ctrl_pkg::*;
#(
    parameter int BLANK_LINES = 2,
    parameter int FCNT_W      = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              HSync,
    input  logic              VDE,
    input  logic              cpu_req_valid,
    input  logic [2:0]        cpu_req_mode,
    output logic              cpu_req_ready,
    input  logic              btn_next,
    input  logic              hold,
    output logic [5:0]        Display,
    output logic [2:0]        mode_out,
    output logic              pending,
    output logic              err,
    output logic              frame_tick,
    output logic [FCNT_W-1:0] frame_count
);

    logic       boundary;
    logic       btn_q;
    logic       btn_rise;
    logic       cpu_pend;
    logic       cpu_acc;
    logic       cpu_legal;
    logic       apply;
    logic       pending_n;
    logic       err_n;
    pend_slot_t slot, slot_n;

    frame_boundary_det #(
        .BLANK_LINES(BLANK_LINES)
    ) u_fbd (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .HSync      (HSync),
        .VDE        (VDE),
        .boundary   (boundary),
        .frame_tick (frame_tick)
    );

    assign cpu_pend      = pending & (slot.src == SRC_CPU);
    // forced high while in reset so software never sees a stall from stale state
    assign cpu_req_ready = ~RST_N | ~cpu_pend;
    assign cpu_acc       = cpu_req_valid & cpu_req_ready;
    assign cpu_legal     = cpu_req_mode < 3'(NUM_MODES);
    assign btn_rise      = btn_next & ~btn_q;
    assign apply         = boundary & pending & ~hold;

    // apply consumes the pre-edge slot; a request on the same edge refills it
    always_comb begin
        slot_n    = slot;
        pending_n = pending;
        err_n     = 1'b0;
        if (apply)
            pending_n = 1'b0;
        if (cpu_acc) begin
            if (cpu_legal) begin
                slot_n.mode = cpu_req_mode;
                slot_n.src  = SRC_CPU;
                pending_n   = 1'b1;
            end else begin
                err_n = 1'b1;
            end
        end else if (btn_rise && !cpu_pend) begin
            slot_n.mode = next_mode(pending ? slot.mode : mode_out);
            slot_n.src  = SRC_BTN;
            pending_n   = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            btn_q       <= 1'b0;
            slot        <= '0;
            pending     <= 1'b0;
            err         <= 1'b0;
            mode_out    <= MODE_RGB;
            Display     <= '0;
            frame_count <= '0;
        end else begin
            btn_q   <= btn_next;
            slot    <= slot_n;
            pending <= pending_n;
            err     <= err_n;
            if (boundary)
                frame_count <= frame_count + 1'b1;
            if (apply) begin
                mode_out <= slot.mode;
                Display  <= mode_to_onehot(slot.mode);
            end
        end
    end

endmodule
